draw_scheduler: RTL and testbench

//  Per-frame sequencer and VGA-port owner for the game display. On each frame

---
 rtl/draw_scheduler.sv | 245 ++++++++++++++++++++++++
 tb/tb_draw_scheduler.sv | 226 ++++++++++++++++++++++
 2 files changed

// File: rtl/draw_scheduler.sv
// ---------------------------------------------------------------------------
// draw_scheduler
//
// Per-frame sequencer and owner of the single VGA adapter write port.
//
// On every accepted frame tick the scheduler runs this fixed order:
//   1. erase the old sprites
//   2. pulse one game-state update (suppressed while halted)
//   3. draw the walls
//   4. draw the bird
// While a drawer is running, its pixel stream is routed to the VGA port.
//
// Ports
//   clk, reset                  clock, asynchronous active-high reset
//   frame_tick                  1-cycle pulse per frame
//   halt                        freeze level, sampled when a frame starts
//   er_/wl_/bd_start            1-cycle start pulse to erase/wall/bird drawer
//   er_/wl_/bd_done             drawer finished (pulse or level)
//   er_/wl_/bd_x, _y, _c, _plot drawer pixel streams
//   game_update                 1-cycle pulse that advances bird/wall positions
//   vga_x, vga_y, vga_colour    muxed pixel stream to vga_adapter
//   vga_plot                    muxed write enable
//   busy                        high in every state except IDLE
//   frame_overrun               sticky: frame_tick arrived while busy
//   timeout_err                 sticky: a drawer was aborted by the watchdog
//   dbg_state                   current FSM state, for observation only
//
// Handshakes: a start pulse is asserted for exactly one cycle. The matching
// done is sampled on every clock edge while its wait state is active,
// including the edge that ends the first cycle of that state. A done seen
// in any other state is ignored. No ready/back-pressure exists on the VGA
// side; vga_plot is a plain write strobe.
// ---------------------------------------------------------------------------
module draw_scheduler #(
  parameter int X_W     = 8,
  parameter int Y_W     = 7,
  parameter int COL_W   = 3,
  parameter int TIMEOUT = 20000
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             frame_tick,
  input  logic             halt,
  output logic             er_start,
  output logic             wl_start,
  output logic             bd_start,
  input  logic             er_done,
  input  logic             wl_done,
  input  logic             bd_done,
  input  logic [X_W-1:0]   er_x,
  input  logic [X_W-1:0]   wl_x,
  input  logic [X_W-1:0]   bd_x,
  input  logic [Y_W-1:0]   er_y,
  input  logic [Y_W-1:0]   wl_y,
  input  logic [Y_W-1:0]   bd_y,
  input  logic [COL_W-1:0] er_c,
  input  logic [COL_W-1:0] wl_c,
  input  logic [COL_W-1:0] bd_c,
  input  logic             er_plot,
  input  logic             wl_plot,
  input  logic             bd_plot,
  output logic             game_update,
  output logic [X_W-1:0]   vga_x,
  output logic [Y_W-1:0]   vga_y,
  output logic [COL_W-1:0] vga_colour,
  output logic             vga_plot,
  output logic             busy,
  output logic             frame_overrun,
  output logic             timeout_err,
  output logic [2:0]       dbg_state
);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    ER_ST = 3'd1,
    ER_WT = 3'd2,
    UPD   = 3'd3,
    WL_ST = 3'd4,
    WL_WT = 3'd5,
    BD_ST = 3'd6,
    BD_WT = 3'd7
  } state_t;

  // The watchdog counts 0 .. TIMEOUT-1, so $clog2(TIMEOUT) bits are enough.
  localparam int WD_W = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
  localparam logic [WD_W-1:0] WD_LAST = WD_W'(TIMEOUT - 1);

  state_t          state_q;
  logic [WD_W-1:0] wd_q;
  logic            halt_lat_q;
  logic            er_start_q;
  logic            wl_start_q;
  logic            bd_start_q;
  logic            game_update_q;
  logic            busy_q;
  logic            overrun_q;
  logic            timeout_q;

  // The done of the drawer that owns the current wait state. Other drawers'
  // done inputs never reach the FSM.
  logic wt_done;
  // The phase ends on done, or when the watchdog has reached its last value.
  logic wd_last;

  always_comb begin
    wt_done = 1'b0;
    case (state_q)
      ER_WT:   wt_done = er_done;
      WL_WT:   wt_done = wl_done;
      BD_WT:   wt_done = bd_done;
      default: wt_done = 1'b0;
    endcase
  end

  assign wd_last = (wd_q == WD_LAST);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q       <= IDLE;
      wd_q          <= '0;
      halt_lat_q    <= 1'b0;
      er_start_q    <= 1'b0;
      wl_start_q    <= 1'b0;
      bd_start_q    <= 1'b0;
      game_update_q <= 1'b0;
      busy_q        <= 1'b0;
      overrun_q     <= 1'b0;
      timeout_q     <= 1'b0;
    end else begin
      // Pulses default low; each is raised on the edge entering its state.
      er_start_q    <= 1'b0;
      wl_start_q    <= 1'b0;
      bd_start_q    <= 1'b0;
      game_update_q <= 1'b0;

      // A tick outside IDLE is dropped, including the last BD_WT cycle.
      if (frame_tick && (state_q != IDLE)) begin
        overrun_q <= 1'b1;
      end

      case (state_q)
        IDLE: begin
          if (frame_tick) begin
            state_q    <= ER_ST;
            er_start_q <= 1'b1;
            halt_lat_q <= halt;
            busy_q     <= 1'b1;
          end
        end
        ER_ST: begin
          state_q <= ER_WT;
          wd_q    <= '0;
        end
        ER_WT: begin
          if (wt_done || wd_last) begin
            state_q       <= UPD;
            game_update_q <= ~halt_lat_q;
            if (!wt_done) timeout_q <= 1'b1;
          end else begin
            wd_q <= wd_q + 1'b1;
          end
        end
        UPD: begin
          state_q    <= WL_ST;
          wl_start_q <= 1'b1;
        end
        WL_ST: begin
          state_q <= WL_WT;
          wd_q    <= '0;
        end
        WL_WT: begin
          if (wt_done || wd_last) begin
            state_q    <= BD_ST;
            bd_start_q <= 1'b1;
            if (!wt_done) timeout_q <= 1'b1;
          end else begin
            wd_q <= wd_q + 1'b1;
          end
        end
        BD_ST: begin
          state_q <= BD_WT;
          wd_q    <= '0;
        end
        BD_WT: begin
          if (wt_done || wd_last) begin
            state_q <= IDLE;
            busy_q  <= 1'b0;
            if (!wt_done) timeout_q <= 1'b1;
          end else begin
            wd_q <= wd_q + 1'b1;
          end
        end
        default: begin
          state_q <= IDLE;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  // VGA port mux: decoded from state only, so an async reset blanks the
  // port in the same instant it forces IDLE.
  always_comb begin
    vga_x      = '0;
    vga_y      = '0;
    vga_colour = '0;
    vga_plot   = 1'b0;
    case (state_q)
      ER_WT: begin
        vga_x      = er_x;
        vga_y      = er_y;
        vga_colour = er_c;
        vga_plot   = er_plot;
      end
      WL_WT: begin
        vga_x      = wl_x;
        vga_y      = wl_y;
        vga_colour = wl_c;
        vga_plot   = wl_plot;
      end
      BD_WT: begin
        vga_x      = bd_x;
        vga_y      = bd_y;
        vga_colour = bd_c;
        vga_plot   = bd_plot;
      end
      default: begin
        vga_x      = '0;
        vga_y      = '0;
        vga_colour = '0;
        vga_plot   = 1'b0;
      end
    endcase
  end

  assign er_start      = er_start_q;
  assign wl_start      = wl_start_q;
  assign bd_start      = bd_start_q;
  assign game_update   = game_update_q;
  assign busy          = busy_q;
  assign frame_overrun = overrun_q;
  assign timeout_err   = timeout_q;
  assign dbg_state     = state_q;

endmodule

// File: tb/tb_draw_scheduler.sv
// ---------------------------------------------------------------------------
// tb_draw_scheduler
//
// Frame-level bench for draw_scheduler. For every frame the bench picks the
// drawer response delays, halt value and optional stray tick, then derives
// the whole expected timeline of the frame from the phase-length rules:
// a wait phase lasts delay+1 cycles, capped at TIMEOUT cycles, and aborts
// (timeout) if the drawer never answers within that window.
// Inputs are driven on the falling edge; outputs are sampled 1 time unit later.
// ---------------------------------------------------------------------------
module tb_draw_scheduler;

  localparam int X_W   = 8;
  localparam int Y_W   = 7;
  localparam int COL_W = 3;
  localparam int TMO   = 16;
  localparam int NEVER = 99;

  logic             clk;
  logic             reset;
  logic             frame_tick;
  logic             halt;
  logic             er_start, wl_start, bd_start;
  logic             er_done, wl_done, bd_done;
  logic [X_W-1:0]   er_x, wl_x, bd_x;
  logic [Y_W-1:0]   er_y, wl_y, bd_y;
  logic [COL_W-1:0] er_c, wl_c, bd_c;
  logic             er_plot, wl_plot, bd_plot;
  logic             game_update;
  logic [X_W-1:0]   vga_x;
  logic [Y_W-1:0]   vga_y;
  logic [COL_W-1:0] vga_colour;
  logic             vga_plot;
  logic             busy;
  logic             frame_overrun;
  logic             timeout_err;
  logic [2:0]       dbg_state;

  draw_scheduler #(
    .X_W(X_W), .Y_W(Y_W), .COL_W(COL_W), .TIMEOUT(TMO)
  ) dut (
    .clk(clk), .reset(reset), .frame_tick(frame_tick), .halt(halt),
    .er_start(er_start), .wl_start(wl_start), .bd_start(bd_start),
    .er_done(er_done), .wl_done(wl_done), .bd_done(bd_done),
    .er_x(er_x), .wl_x(wl_x), .bd_x(bd_x),
    .er_y(er_y), .wl_y(wl_y), .bd_y(bd_y),
    .er_c(er_c), .wl_c(wl_c), .bd_c(bd_c),
    .er_plot(er_plot), .wl_plot(wl_plot), .bd_plot(bd_plot),
    .game_update(game_update),
    .vga_x(vga_x), .vga_y(vga_y), .vga_colour(vga_colour), .vga_plot(vga_plot),
    .busy(busy), .frame_overrun(frame_overrun), .timeout_err(timeout_err),
    .dbg_state(dbg_state)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- scoreboard ----------------
  int checks = 0;
  int errors = 0;
  logic [6:0] exp_q[$];   // per-cycle control vector of the current frame
  bit m_ovr = 0;          // model sticky flags
  bit m_tmo = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  function automatic logic [6:0] ctl_vec();
    return {frame_overrun, timeout_err, busy, er_start, game_update, wl_start, bd_start};
  endfunction

  // ---------------- driver tasks ----------------
  task automatic randomize_streams();
    er_x = X_W'($urandom_range(0, 159)); er_y = Y_W'($urandom_range(0, 119));
    wl_x = X_W'($urandom_range(0, 159)); wl_y = Y_W'($urandom_range(0, 119));
    bd_x = X_W'($urandom_range(0, 159)); bd_y = Y_W'($urandom_range(0, 119));
    er_c = COL_W'($urandom_range(0, 7));
    wl_c = COL_W'($urandom_range(0, 7));
    bd_c = COL_W'($urandom_range(0, 7));
    er_plot = 1'($urandom_range(0, 1));
    wl_plot = 1'($urandom_range(0, 1));
    bd_plot = 1'($urandom_range(0, 1));
  endtask

  // Wait-phase length in cycles for a drawer answering 'd' cycles after the
  // cycle following its start pulse.
  function automatic int phase_len(input int d);
    return (d <= TMO - 1) ? d + 1 : TMO;
  endfunction

  // de/dw/db: drawer delays (>= TMO means never done)
  // xt: cycle of a stray tick (-1 none, -2 last BD_WT cycle)
  // rst_at: cycle to pulse reset (-1 none, -2 early in BD_WT)
  // hsel: halt at the tick (0, 1, 2 = random)
  task automatic run_frame(input int de, input int dw, input int db,
                           input int xt_in, input int rst_in, input int hsel);
    int le, lw, lb, a, bs, b, xt, rst_at;
    int er_due, wl_due, bd_due;
    bit h, to_e, to_w, to_b;
    bit e_busy, e_er, e_gu, e_wl, e_bd, e_ovr, e_tmo, in_er;
    int owner;
    logic [18:0] exp_vga;

    h    = (hsel == 2) ? 1'($urandom_range(0, 1)) : (hsel == 1);
    le   = phase_len(de);
    lw   = phase_len(dw);
    lb   = phase_len(db);
    to_e = (de >= TMO);
    to_w = (dw >= TMO);
    to_b = (db >= TMO);
    a    = 2 + le;        // UPD cycle
    bs   = a + 2 + lw;    // bd_start cycle
    b    = bs + 1 + lb;   // back in IDLE
    xt     = (xt_in == -2) ? b - 1 : xt_in;
    rst_at = (rst_in == -2) ? bs + 2 : rst_in;

    exp_q.delete();
    for (int r = 0; r <= b; r++) begin
      e_ovr  = m_ovr || (xt >= 0 && r > xt);
      e_tmo  = m_tmo || (to_e && r >= a) || (to_w && r >= bs) || (to_b && r >= b);
      e_busy = (r >= 1) && (r < b);
      e_er   = (r == 1);
      e_gu   = (r == a) && !h;
      e_wl   = (r == a + 1);
      e_bd   = (r == bs);
      exp_q.push_back({e_ovr, e_tmo, e_busy, e_er, e_gu, e_wl, e_bd});
    end

    er_due = -1; wl_due = -1; bd_due = -1;
    for (int r = 0; r <= b; r++) begin
      @(negedge clk);
      in_er      = (r >= 2) && (r <= 1 + le);
      frame_tick = (r == 0) || (r == xt);
      halt       = (r == 0) ? h : 1'($urandom_range(0, 1));
      randomize_streams();
      er_done = (r == er_due);
      // Non-owner done pulses while erasing must be ignored.
      wl_done = (r == wl_due) || (in_er && ($urandom_range(0, 1) == 1));
      bd_done = (r == bd_due) || (in_er && ($urandom_range(0, 1) == 1));
      #1;
      if (r == rst_at) begin
        reset = 1'b1;
        #1;
        check("rst_async_ctl", 32'(ctl_vec()), 32'd0);
        check("rst_async_vga", 32'({vga_x, vga_y, vga_colour, vga_plot}), 32'd0);
        repeat (2) @(negedge clk);
        frame_tick = 1'b0; er_done = 1'b0; wl_done = 1'b0; bd_done = 1'b0;
        reset = 1'b0;
        #1;
        check("rst_release", 32'(ctl_vec()), 32'd0);
        m_ovr = 0;
        m_tmo = 0;
        exp_q.delete();
        return;
      end
      check("ctl", 32'(ctl_vec()), 32'(exp_q.pop_front()));
      if (r >= 2 && r <= 1 + le)             owner = 1;
      else if (r >= a + 2 && r <= a + 1 + lw) owner = 2;
      else if (r >= bs + 1 && r <= bs + lb)   owner = 3;
      else                                    owner = 0;
      case (owner)
        1:       exp_vga = {er_x, er_y, er_c, er_plot};
        2:       exp_vga = {wl_x, wl_y, wl_c, wl_plot};
        3:       exp_vga = {bd_x, bd_y, bd_c, bd_plot};
        default: exp_vga = '0;
      endcase
      check("vga", 32'({vga_x, vga_y, vga_colour, vga_plot}), 32'(exp_vga));
      // Drawer models react to the start pulses they observe.
      if (er_start) er_due = (de < TMO) ? r + 1 + de : -1;
      if (wl_start) wl_due = (dw < TMO) ? r + 1 + dw : -1;
      if (bd_start) bd_due = (db < TMO) ? r + 1 + db : -1;
    end
    m_ovr = m_ovr || (xt >= 0);
    m_tmo = m_tmo || to_e || to_w || to_b;
  endtask

  function automatic int rand_delay();
    return ($urandom_range(0, 9) == 0) ? NEVER : int'($urandom_range(0, TMO - 1));
  endfunction

  // ---------------- main sequence ----------------
  initial begin
    reset = 1'b1; frame_tick = 1'b0; halt = 1'b0;
    er_done = 1'b0; wl_done = 1'b0; bd_done = 1'b0;
    randomize_streams();
    repeat (3) @(negedge clk);
    check("reset_ctl", 32'(ctl_vec()), 32'd0);
    check("reset_vga", 32'({vga_x, vga_y, vga_colour, vga_plot}), 32'd0);
    reset = 1'b0;
    @(negedge clk);
    #1;
    check("post_reset_ctl", 32'(ctl_vec()), 32'd0);

    run_frame(5, 5, 5, -1, -1, 0);      // basic order, one update
    run_frame(5, 5, 5, -1, -1, 1);      // halted frame, no update
    run_frame(0, 0, 0, -1, -1, 2);      // done on first wait cycle
    run_frame(15, 15, 15, -1, -1, 2);   // done on the watchdog's last cycle
    run_frame(3, 4, NEVER, -1, -1, 0);  // bird drawer never answers
    run_frame(2, 2, 2, -1, -1, 0);      // normal frame after a timeout
    run_frame(4, 6, 3, 10, -1, 2);      // stray tick during WL_WT
    run_frame(3, 3, 3, -2, -1, 2);      // stray tick on the BD_WT exit cycle

    for (int i = 0; i < 25; i++) begin
      int de, dw, db, xt;
      de = rand_delay();
      dw = rand_delay();
      db = rand_delay();
      xt = ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 6)) : -1;
      run_frame(de, dw, db, xt, -1, 2);
    end

    run_frame(NEVER, 2, 2, 5, -1, 2);   // sets both sticky flags
    run_frame(3, 3, 6, -1, -2, 2);      // reset in BD_WT clears everything
    run_frame(4, 4, 4, -1, -1, 0);      // clean frame after reset

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
